datapath_seq: RTL



---
 rtl/datapath_seq_if.sv | 41 ++++
 rtl/datapath_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/datapath_seq_if.sv
// Micro-op handshake and result bus between the control FSM and datapath_seq.
// The master drives micro-ops and live memory/PC values. The slave is the datapath.
interface datapath_seq_if #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
);
  localparam int RA = $clog2(NREG);

  logic          op_valid;
  logic          op_ready;
  logic [RA-1:0] op_rn;
  logic [RA-1:0] op_rm;
  logic [RA-1:0] op_rd;
  logic [1:0]    op_shift;
  logic          op_asel;
  logic          op_bsel;
  logic [1:0]    op_alu;
  logic [1:0]    op_vsel;
  logic          op_wb;
  logic          op_setflags;
  logic [W-1:0]  sximm8;
  logic [W-1:0]  sximm5;
  logic [W-1:0]  mdata;
  logic [PCW-1:0] pc;
  logic          done;
  logic [W-1:0]  datapath_out;
  logic [2:0]    status_out;

  modport master (
    output op_valid, op_rn, op_rm, op_rd, op_shift, op_asel, op_bsel,
           op_alu, op_vsel, op_wb, op_setflags, sximm8, sximm5, mdata, pc,
    input  op_ready, done, datapath_out, status_out
  );

  modport slave (
    input  op_valid, op_rn, op_rm, op_rd, op_shift, op_asel, op_bsel,
           op_alu, op_vsel, op_wb, op_setflags, sximm8, sximm5, mdata, pc,
    output op_ready, done, datapath_out, status_out
  );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing RISC datapath. Each accepted micro-op walks IDLE -> RDA -> RDB -> EXEC -> WB.
// Direct-source ops jump from IDLE straight to WB.
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
) (
  input  logic           clk,
  input  logic           reset,
  datapath_seq_if.slave  bus
);
  localparam int RA = $clog2(NREG);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [RA-1:0] rn;
    logic [RA-1:0] rm;
    logic [RA-1:0] rd;
    logic [1:0]    shift;
    logic          asel;
    logic          bsel;
    logic [1:0]    alu;
    logic [1:0]    vsel;
    logic          wb;
    logic          setflags;
  } uop_t;

  state_t       state, state_nxt;
  uop_t         uop_q;
  logic [W-1:0] imm8_q, imm5_q;
  logic [W-1:0] a_q, b_q, c_q;
  logic [2:0]   status_q;
  logic [W-1:0] regs [NREG];

  logic [W-1:0] b_shift, ain, bin, alu_res, wb_data;
  logic         alu_v;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first, so no path leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.op_valid) state_nxt = (bus.op_vsel == 2'b00) ? S_RDA : S_WB;
      S_RDA:   state_nxt = S_RDB;
      S_RDB:   state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready = (state == S_IDLE);
    bus.done     = (state == S_WB);
  end

  // ---------------- Micro-op capture ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      uop_q  <= '0;
      imm8_q <= '0;
      imm5_q <= '0;
    end else if (state == S_IDLE && bus.op_valid) begin
      uop_q  <= '{rn: bus.op_rn, rm: bus.op_rm, rd: bus.op_rd, shift: bus.op_shift,
                  asel: bus.op_asel, bsel: bus.op_bsel, alu: bus.op_alu,
                  vsel: bus.op_vsel, wb: bus.op_wb, setflags: bus.op_setflags};
      imm8_q <= bus.sximm8;
      imm5_q <= bus.sximm5;
    end
  end

  // ---------------- Shifter and ALU ----------------
  always_comb begin
    case (uop_q.shift)
      2'b01:   b_shift = {b_q[W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[W-1:1]};
      2'b11:   b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase

    ain     = uop_q.asel ? '0 : a_q;
    bin     = uop_q.bsel ? imm5_q : b_shift;
    alu_res = '0;
    alu_v   = 1'b0;

    // Overflow: operands that look alike in sign (after negating B for SUB)
    // produce a result of the opposite sign.
    case (uop_q.alu)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[W-1] == bin[W-1]) && (alu_res[W-1] != ain[W-1]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[W-1] != bin[W-1]) && (alu_res[W-1] != ain[W-1]);
      end
      2'b10:   alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
  end

  // The mdata and pc values are taken live, during the WB cycle itself.
  always_comb begin
    case (uop_q.vsel)
      2'b11:   wb_data = bus.mdata;
      2'b10:   wb_data = imm8_q;
      2'b01:   wb_data = W'(bus.pc);
      default: wb_data = c_q;
    endcase
  end

  // ---------------- Operand, result and status registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        S_RDA:  a_q <= regs[uop_q.rn];
        S_RDB:  b_q <= regs[uop_q.rm];
        S_EXEC: begin
          c_q <= alu_res;
          if (uop_q.setflags) status_q <= {alu_v, alu_res[W-1], (alu_res == '0)};
        end
        default: ;
      endcase
    end
  end

  // ---------------- Register file ----------------
  // NOTE: the register file is architectural state that must read back as zero after reset,
  // so it is built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == S_WB && uop_q.wb) begin
      regs[uop_q.rd] <= wb_data;
    end
  end

  assign bus.datapath_out = c_q;
  assign bus.status_out   = status_q;
endmodule
